// File: rtl/sram_param_if.sv
// Request/response bundle for sram_param: the requester drives the master side,
// the memory drives the slave side.
interface sram_param_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
);
   logic                  en;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     din;
   logic [DATA_W/8-1:0]   wmask;
   logic [DATA_W-1:0]     dout;
   logic                  rvalid;
   logic                  busy;

   modport master (
      output en, we, addr, din, wmask,
      input  dout, rvalid, busy
   );

   modport slave (
      input  en, we, addr, din, wmask,
      output dout, rvalid, busy
   );
endinterface

// File: rtl/sram_param.sv
// Parametrised single-port SRAM with byte write mask, post-reset clear engine and
// read-valid strobe. Define SRAM_OUT_REG_EN to add a second output register stage.
module sram_param #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 4,
   parameter bit          WRITE_FIRST = 1'b0
) (
   input logic        clk,
   input logic        rst,
   sram_param_if.slave bus
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned NB    = DATA_W/8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_busy;
   logic [DATA_W-1:0]   r_dout;
   logic                r_rvalid;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [DATA_W-1:0]   w_old;
   logic [DATA_W-1:0]   w_merged;
   logic                w_accept;

   // Byte-merge of the addressed word with the masked write data
   always_comb begin
      w_old    = r_mem[bus.addr];
      w_merged = w_old;
      for (int unsigned i = 0; i < NB; i++) begin
         if (bus.wmask[i]) begin
            w_merged[8*i +: 8] = bus.din[8*i +: 8];
         end
      end
   end

   assign w_accept = (r_state == ST_READY) && bus.en;

   // Control FSM: clear sweep after reset, then one access per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_CLEAR;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
         r_dout   <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
               r_cnt <= r_cnt + ADDR_W'(1);
               if (r_cnt == ADDR_W'(DEPTH-1)) begin
                  r_state <= ST_READY;
                  r_busy  <= 1'b0;
               end
            end
            ST_READY: begin
               if (bus.en) begin
                  if (!bus.we) begin
                     r_dout   <= w_old;
                     r_rvalid <= 1'b1;
                  end else if (WRITE_FIRST) begin
                     r_dout   <= w_merged;
                     r_rvalid <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_CLEAR;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage array: only the clear engine or an accepted write touches it
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
         end else if (w_accept && bus.we) begin
            r_mem[bus.addr] <= w_merged;
         end
      end
   end

   assign bus.busy = r_busy;

`ifdef SRAM_OUT_REG_EN
   logic [DATA_W-1:0] r_dout_q;
   logic              r_rvalid_q;

   // Free-running output stage, adds one cycle of read latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout_q   <= '0;
         r_rvalid_q <= 1'b0;
      end else begin
         r_dout_q   <= r_dout;
         r_rvalid_q <= r_rvalid;
      end
   end

   assign bus.dout   = r_dout_q;
   assign bus.rvalid = r_rvalid_q;
`else
   assign bus.dout   = r_dout;
   assign bus.rvalid = r_rvalid;
`endif

endmodule

// File: doc/sram_param.md
# sram_param

Parametrised single-port synchronous SRAM replacing the fixed 16x8 memory: configurable width and depth, per-byte write mask, selectable read-during-write behaviour, and a read-valid strobe. After reset a hardware clear engine zeroes every word, holding off requests behind `busy`. Sits between datapath blocks and scratch storage wherever a small on-chip buffer is needed.

## Interface

- `DATA_W`, 32, word width in bits; multiple of 8
- `ADDR_W`, 4, address width; DEPTH = 2**ADDR_W words
- `WRITE_FIRST`, 0, 0 = `dout` unchanged on write; 1 = `dout` returns the merged written word

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  request strobe; ignored while `busy`=1
- `we`  in  1  1 = write, 0 = read (qualified by `en`)
- `addr`  in  ADDR_W  word address
- `din`  in  DATA_W  write data
- `wmask`  in  DATA_W/8  byte enables; bit i covers `din[8i+7:8i]`
- `dout`  out  DATA_W  read data, held between reads
- `rvalid`  out  1  one-cycle pulse marking new `dout`
- `busy`  out  1  clear engine active; requests dropped

## Operation

- FSM states: CLEAR, READY. `rst`=1 -> state CLEAR, clear counter 0, `dout`=0, `rvalid`=0, `busy`=1, pipeline regs 0; no memory write while `rst`=1.
- CLEAR (`rst`=0): each edge writes 0 to `mem[cnt]`, cnt+1; at cnt = DEPTH-1 writes last word, moves to READY. `busy` = (state==CLEAR).
- `rst` mid-clear: counter returns to 0, clear restarts from address 0 after release.
- READY, `en`=0: no memory change, `dout` held, `rvalid`=0.
- Read (`en`=1, `we`=0): `dout` <= `mem[addr]`, `rvalid`=1.
- Write (`en`=1, `we`=1): for each i with `wmask[i]`=1, byte i of `mem[addr]` <= byte i of `din`; other bytes keep old value. `wmask`=0 -> no change.
  - WRITE_FIRST=0: `dout` held, `rvalid`=0.
  - WRITE_FIRST=1: `dout` <= merged word (new bytes where masked, old elsewhere), `rvalid`=1.
- Back-to-back requests accepted every cycle; write then read to same address on next cycle returns new data.
- Requests with `en`=1 during `busy`=1 are discarded: no write, no `rvalid`.
- Memory contents not covered by reset other than via clear engine.

## Timing

- Clear: `busy` high during `rst` and for exactly DEPTH edges after the first edge with `rst`=0; request presented at edge DEPTH after release is accepted.
- Read latency 1 cycle (request edge -> `dout`/`rvalid` valid after same edge); 2 cycles with output register.
- `rvalid` high for exactly one cycle per returning access.
- Throughput 1 access/cycle, no stalls in READY.

## Configuration

- `SRAM_OUT_REG_EN` defined: extra output stage; `dout` and `rvalid` delayed one cycle (latency 2), stage reset to 0 by `rst`, stage runs every cycle (not gated by `en`). Undefined: latency 1, `dout` driven straight from the array read register.

## Test plan

- Reset, DATA_W=32, ADDR_W=4: `busy`=1 for 16 cycles after release, then 0; read all 16 addresses -> each 0x00000000, `rvalid` pulse per read.
- Write addr 3 `din`=0xDEADBEEF `wmask`=0xF, then write addr 3 `din`=0x11223344 `wmask`=0x5 -> read addr 3 returns 0xDE22BE44.
- WRITE_FIRST=1: write addr 7 0xCAFEF00D `wmask`=0xF -> next cycle `dout`=0xCAFEF00D, `rvalid`=1; WRITE_FIRST=0 same stimulus -> `dout` unchanged, `rvalid`=0.
- `rst` at clear cycle 5 after earlier write of 0xA5A5A5A5 to addr 12 -> clear restarts, `busy` 16 more cycles, addr 12 reads 0; write with `en`=1 during `busy` leaves no trace.
- Read addr 15 then read addr 0 back-to-back -> two consecutive `rvalid` pulses, data in order; with `SRAM_OUT_REG_EN` each appears one cycle later.
